cci_mpf_shim_buffer_nchan: RTL and testbench

CCI_MPF_SHIM_BUFFER_NCHAN -- requirements
Module: cci_mpf_shim_buffer_nchan

---
 rtl/cci_mpf_shim_buffer_nchan_if.sv | 27 ++
 rtl/cci_mpf_shim_buffer_nchan.sv | 108 ++++++++++
 tb/tb_cci_mpf_shim_buffer_nchan.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/cci_mpf_shim_buffer_nchan_if.sv
// Bundle of per-channel request, head and status signals for the N-channel shim buffer.
// Producer/consumer side uses the master modport; the buffer uses slave.
interface cci_mpf_shim_buffer_nchan_if #(
  parameter int N_CHANNELS  = 2,
  parameter int N_DATA_BITS = 64,
  parameter int CNT_BITS    = 3
);
  logic [N_CHANNELS*N_DATA_BITS-1:0] enq_data;
  logic [N_CHANNELS-1:0]             enq_en;
  logic [N_CHANNELS-1:0]             almostFull;
  logic [N_CHANNELS*N_DATA_BITS-1:0] first;
  logic [N_CHANNELS-1:0]             first_valid;
  logic [N_CHANNELS-1:0]             deq_en;
  logic [N_CHANNELS*CNT_BITS-1:0]    occupancy;
  logic [N_CHANNELS-1:0]             overflow_err;
  logic [N_CHANNELS*CNT_BITS-1:0]    high_water;

  modport master (
    output enq_data, enq_en, deq_en,
    input  almostFull, first, first_valid, occupancy, overflow_err, high_water
  );

  modport slave (
    input  enq_data, enq_en, deq_en,
    output almostFull, first, first_valid, occupancy, overflow_err, high_water
  );
endinterface

// File: rtl/cci_mpf_shim_buffer_nchan.sv
// N independent in-order FIFOs with optional same-cycle bypass per channel.
// Define CCI_MPF_SHIM_BUFFER_STATS_EN to enable per-channel high-water tracking.
module cci_mpf_shim_buffer_nchan #(
  parameter int N_CHANNELS                  = 2,
  parameter int N_DATA_BITS                 = 64,
  parameter int N_ENTRIES                   = 6,
  parameter int THRESHOLD                   = 4,
  parameter logic [N_CHANNELS-1:0] BYPASS_MASK = '0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  cci_mpf_shim_buffer_nchan_if.slave   bus
);

  localparam int CNT_BITS = $clog2(N_ENTRIES + 1);
  localparam int PTR_BITS = $clog2(N_ENTRIES);
  localparam logic [CNT_BITS-1:0] FULL_CNT = CNT_BITS'(N_ENTRIES);
  localparam logic [CNT_BITS-1:0] AF_CNT   = CNT_BITS'(N_ENTRIES - THRESHOLD);
  localparam logic [PTR_BITS-1:0] LAST_PTR = PTR_BITS'(N_ENTRIES - 1);

  for (genvar g = 0; g < N_CHANNELS; g++) begin : g_chan
    logic [N_DATA_BITS-1:0] r_mem [N_ENTRIES];
    logic [PTR_BITS-1:0]    r_wr_ptr;
    logic [PTR_BITS-1:0]    r_rd_ptr;
    logic [CNT_BITS-1:0]    r_cnt;
    logic [CNT_BITS-1:0]    w_cnt_nxt;
    logic                   r_ovf;
    logic [N_DATA_BITS-1:0] w_enq_data;
    logic                   w_enq;
    logic                   w_empty;
    logic                   w_full;
    logic                   w_byp;
    logic                   w_valid;
    logic                   w_take;
    logic                   w_push;
    logic                   w_pop;

    assign w_enq_data = bus.enq_data[g*N_DATA_BITS +: N_DATA_BITS];
    assign w_enq      = bus.enq_en[g];
    assign w_empty    = (r_cnt == '0);
    assign w_full     = (r_cnt == FULL_CNT);
    // Bypass only applies while the FIFO is empty, so ordering is preserved.
    assign w_byp      = BYPASS_MASK[g] && w_empty;
    assign w_valid    = w_byp ? w_enq : !w_empty;
    assign w_take     = bus.deq_en[g] && w_valid;
    assign w_pop      = w_take && !w_byp;
    // A bypassed entry consumed in the same cycle is never stored.
    assign w_push     = w_enq && !(w_byp && w_take) && (!w_full || w_take);

    always_comb begin
      w_cnt_nxt = r_cnt;
      if (w_push && !w_pop) begin
        w_cnt_nxt = r_cnt + CNT_BITS'(1);
      end else if (!w_push && w_pop) begin
        w_cnt_nxt = r_cnt - CNT_BITS'(1);
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_cnt    <= '0;
        r_ovf    <= 1'b0;
      end else begin
        r_cnt <= w_cnt_nxt;
        if (w_push) begin
          r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PTR_BITS'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PTR_BITS'(1);
        end
        if (w_enq && w_full && !w_take) begin
          r_ovf <= 1'b1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_enq_data;
      end
    end

    assign bus.first[g*N_DATA_BITS +: N_DATA_BITS] = w_byp ? w_enq_data : r_mem[r_rd_ptr];
    assign bus.first_valid[g]                      = w_valid;
    assign bus.almostFull[g]                       = (r_cnt >= AF_CNT);
    assign bus.occupancy[g*CNT_BITS +: CNT_BITS]   = r_cnt;
    assign bus.overflow_err[g]                     = r_ovf;

`ifdef CCI_MPF_SHIM_BUFFER_STATS_EN
    logic [CNT_BITS-1:0] r_hw;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_hw <= '0;
      end else if (r_cnt > r_hw) begin
        r_hw <= r_cnt;
      end
    end

    assign bus.high_water[g*CNT_BITS +: CNT_BITS] = r_hw;
`else
    assign bus.high_water[g*CNT_BITS +: CNT_BITS] = '0;
`endif
  end

endmodule

// File: tb/tb_cci_mpf_shim_buffer_nchan.sv
// Scoreboard bench for cci_mpf_shim_buffer_nchan: 2 channels, 6 entries, channel 1 bypass.
module tb_cci_mpf_shim_buffer_nchan;

  localparam int NE = 6;
  localparam int CB = 3;
  localparam logic [1:0] BYP = 2'b10;

  logic clk;
  logic reset_n;

  cci_mpf_shim_buffer_nchan_if #(.N_CHANNELS(2), .N_DATA_BITS(16), .CNT_BITS(CB)) bus ();

  cci_mpf_shim_buffer_nchan #(
    .N_CHANNELS (2),
    .N_DATA_BITS(16),
    .N_ENTRIES  (NE),
    .THRESHOLD  (4),
    .BYPASS_MASK(BYP)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [1:0]  m_ovf;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int qsize(input int ch);
    return (ch == 0) ? q0.size() : q1.size();
  endfunction

  // Called just after a rising edge; checks heads mid-cycle and state after the next edge.
  task automatic step(input logic [1:0] en, input logic [15:0] d0, input logic [15:0] d1,
                      input logic [1:0] dq);
    logic [15:0] d;
    logic [15:0] head;
    logic        byp;
    logic        fv;
    logic        take;
    int          sz;
    bus.enq_en   = en;
    bus.enq_data = {d1, d0};
    bus.deq_en   = dq;
    #4;
    for (int ch = 0; ch < 2; ch++) begin
      d    = (ch == 0) ? d0 : d1;
      sz   = qsize(ch);
      byp  = BYP[ch] && (sz == 0);
      fv   = byp ? en[ch] : (sz > 0);
      check_val($sformatf("first_valid[%0d]", ch), 64'(bus.first_valid[ch]), 64'(fv));
      if (fv) begin
        if (byp) head = d;
        else head = (ch == 0) ? q0[0] : q1[0];
        check_val($sformatf("first[%0d]", ch), 64'(bus.first[ch*16 +: 16]), 64'(head));
      end
      take = dq[ch] && fv;
      if (take && !byp) begin
        if (ch == 0) void'(q0.pop_front());
        else void'(q1.pop_front());
      end
      if (en[ch] && !(byp && take)) begin
        if (sz < NE || take) begin
          if (ch == 0) q0.push_back(d);
          else q1.push_back(d);
        end else begin
          m_ovf[ch] = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int ch = 0; ch < 2; ch++) begin
      sz = qsize(ch);
      check_val($sformatf("occupancy[%0d]", ch), 64'(bus.occupancy[ch*CB +: CB]), 64'(sz));
      check_val($sformatf("almostFull[%0d]", ch), 64'(bus.almostFull[ch]), 64'(sz >= 2));
      check_val($sformatf("overflow_err[%0d]", ch), 64'(bus.overflow_err[ch]), 64'(m_ovf[ch]));
    end
  endtask

  task automatic check_cleared(input string tag);
    check_val({tag, " occupancy"}, 64'(bus.occupancy), 64'(0));
    check_val({tag, " overflow_err"}, 64'(bus.overflow_err), 64'(0));
    check_val({tag, " high_water"}, 64'(bus.high_water), 64'(0));
    check_val({tag, " almostFull"}, 64'(bus.almostFull), 64'(0));
    check_val({tag, " first_valid"}, 64'(bus.first_valid), 64'(0));
  endtask

  logic [15:0] hw_exp;

  initial begin
    reset_n      = 1'b0;
    bus.enq_en   = '0;
    bus.enq_data = '0;
    bus.deq_en   = '0;
    m_ovf        = '0;
    #3;
    check_cleared("reset");
    #9 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill ch0 to 6; almostFull after the second entry.
    step(2'b01, 16'h0011, 16'h0, 2'b00);
    step(2'b01, 16'h0022, 16'h0, 2'b00);
    for (int i = 3; i <= 6; i++) step(2'b01, 16'(i * 16'h11), 16'h0, 2'b00);
    // Full: enq+deq accepted, then a lone enq is dropped.
    step(2'b01, 16'h0077, 16'h0, 2'b01);
    step(2'b01, 16'h0088, 16'h0, 2'b00);
    step(2'b00, 16'h0, 16'h0, 2'b00);
    // Pointer wrap while full.
    for (int i = 0; i < 20; i++) step(2'b01, 16'(16'hA0 + i), 16'h0, 2'b01);
    for (int i = 0; i < 7; i++) step(2'b00, 16'h0, 16'h0, 2'b01);

    // Ch1 bypass: same-cycle pass-through, then stored behind a head.
    step(2'b10, 16'h0, 16'h00AB, 2'b10);
    step(2'b10, 16'h0, 16'h00C1, 2'b00);
    step(2'b10, 16'h0, 16'h00C2, 2'b10);
    step(2'b00, 16'h0, 16'h0, 2'b10);
    step(2'b00, 16'h0, 16'h0, 2'b10);

    for (int i = 0; i < 120; i++) begin
      step(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)));
    end
    for (int i = 0; i < 8; i++) step(2'b00, 16'h0, 16'h0, 2'b11);

    // Mid-cycle reset with ch1 holding entries.
    for (int i = 0; i < 3; i++) step(2'b10, 16'h0, 16'(16'h50 + i), 2'b00);
    bus.enq_en = '0;
    bus.deq_en = '0;
    #2 reset_n = 1'b0;
    #1;
    check_cleared("midreset");
    q0.delete();
    q1.delete();
    m_ovf = '0;
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;
    step(2'b00, 16'h0, 16'h0, 2'b00);

    // High-water: fill ch0 to 5, drain.
    for (int i = 0; i < 5; i++) step(2'b01, 16'(16'hE0 + i), 16'h0, 2'b00);
    for (int i = 0; i < 5; i++) step(2'b00, 16'h0, 16'h0, 2'b01);
    step(2'b00, 16'h0, 16'h0, 2'b00);
`ifdef CCI_MPF_SHIM_BUFFER_STATS_EN
    hw_exp = 16'd5;
`else
    hw_exp = 16'd0;
`endif
    check_val("high_water[0]", 64'(bus.high_water[0 +: CB]), 64'(hw_exp));
    check_val("high_water[1]", 64'(bus.high_water[CB +: CB]), 64'(0));

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
